cnt_sched: RTL and testbench



---
 rtl/cnt_sched_pkg.sv | 14 +
 rtl/cnt_sched_rr_arb2.sv | 43 ++++
 rtl/cnt_sched.sv | 156 +++++++++++++++
 tb/tb_cnt_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the two-requester counter burst scheduler.
// Holds FSM state encodings and direction constants used by the top and bench.
package cnt_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cnt_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured requester on a
// tie and moves to the other requester whenever a grant is reported served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       served_i,
  input  logic       served_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_idx_o = ptr_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (served_i) begin
      ptr_d = ~served_idx_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/cnt_sched.sv
// Burst scheduler driving en/up_dwn_n of a shared counter for two requesters,
// with round-robin arbitration and a shadow copy of the counter value.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LEN_W = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             en,
  output logic             up_dwn_n,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] cnt_shadow
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic             en_q, en_d;
  logic             up_q, up_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;

  logic             arb_valid;
  logic             arb_idx;
  logic             arb_ptr;
  logic             served;
  logic             sel_dir;
  logic [LEN_W-1:0] sel_len;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .served_i     (served),
    .served_idx_i (owner_q),
    .gnt_valid_o  (arb_valid),
    .gnt_idx_o    (arb_idx),
    .ptr_o        (arb_ptr)
  );

  // With saturation enabled, a step that would cross the boundary is dropped
  // but still consumes its burst cycle.
  function automatic logic at_bound(input logic [CNT_W-1:0] v, input logic d);
    return (SAT != 0) &&
           (((d == DIR_UP) && (v == '1)) || ((d == DIR_DN) && (v == '0)));
  endfunction

  always_comb begin
    sel_dir = dir[arb_idx];
    sel_len = arb_idx ? len1 : len0;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    owner_d  = owner_q;
    up_d     = up_q;
    en_d     = 1'b0;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    served   = 1'b0;
    // Value the counter holds after this edge; en decisions look at it.
    if (en_q) begin
      shadow_d = up_q ? shadow_q + CNT_W'(1) : shadow_q - CNT_W'(1);
    end else begin
      shadow_d = shadow_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          dir_d   = sel_dir;
          rem_d   = sel_len;
          gnt_d   = 2'b01 << arb_idx;
          if (sel_len != '0) begin
            state_d = ST_RUN;
            up_d    = sel_dir;
            en_d    = ~at_bound(shadow_d, sel_dir);
          end else begin
            state_d = ST_DONE;
            done_d  = 2'b01 << arb_idx;
          end
        end
      end
      ST_RUN: begin
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 2'b01 << owner_q;
        end else begin
          rem_d = rem_q - LEN_W'(1);
          en_d  = ~at_bound(shadow_d, dir_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        served  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      owner_q  <= 1'b0;
      en_q     <= 1'b0;
      up_q     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      owner_q  <= owner_d;
      en_q     <= en_d;
      up_q     <= up_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      shadow_q <= shadow_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign en         = en_q;
  assign up_dwn_n   = up_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign cnt_shadow = shadow_q;

  logic unused_ptr;
  assign unused_ptr = arb_ptr;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: one wrapping instance (SAT=0) and one
// saturating instance (SAT=1) receive identical stimulus.
module tb_cnt_sched;

  localparam int CNT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       dir = 2'b00;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;

  logic [1:0]       gnt_a, done_a, gnt_b, done_b;
  logic             en_a, up_a, busy_a, owner_a;
  logic             en_b, up_b, busy_b, owner_b;
  logic [CNT_W-1:0] sh_a, sh_b;

  int total  = 0;
  int failed = 0;

  // burst observation results
  int         ens_a, ens_b, cyc;
  logic [1:0] done_seen;
  int         stray_gnt;
  int         dir_bad;

  always #5 clk = ~clk;

  cnt_sched #(.CNT_W(CNT_W), .LEN_W(LEN_W), .SAT(0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .len0(len0), .len1(len1),
    .gnt(gnt_a), .done(done_a), .en(en_a), .up_dwn_n(up_a), .busy(busy_a),
    .owner(owner_a), .cnt_shadow(sh_a)
  );

  cnt_sched #(.CNT_W(CNT_W), .LEN_W(LEN_W), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .len0(len0), .len1(len1),
    .gnt(gnt_b), .done(done_b), .en(en_b), .up_dwn_n(up_b), .busy(busy_b),
    .owner(owner_b), .cnt_shadow(sh_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the cycle right after the grant edge; follows the burst until
  // done appears, counting en cycles of both instances.
  task automatic follow_burst(input logic exp_dir);
    ens_a = 0; ens_b = 0; cyc = 0; stray_gnt = 0; dir_bad = 0;
    while (done_a == 2'b00 && cyc < 40) begin
      if (en_a) ens_a++;
      if (en_b) ens_b++;
      if (en_a && up_a !== exp_dir) dir_bad++;
      step();
      cyc++;
      if (gnt_a != 2'b00 || gnt_b != 2'b00) stray_gnt++;
    end
    done_seen = done_a;
  endtask

  // Single-requester command from IDLE; returns after the burst's done cycle.
  task automatic run_cmd(input int idx, input logic d, input int len);
    if (idx == 0) begin
      dir[0] = d; len0 = LEN_W'(len); req = 2'b01;
    end else begin
      dir[1] = d; len1 = LEN_W'(len); req = 2'b10;
    end
    step();
    req = 2'b00;
    follow_burst(d);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("rst_gnt", 32'(gnt_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_en", 32'(en_a), 0);
    check("rst_up", 32'(up_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_owner", 32'(owner_a), 0);
    check("rst_shadow", 32'(sh_a), 0);
    step();
    rst = 1'b0;

    // ---------------- single command: req0 up len 5 ----------------
    dir = 2'b01; len0 = 4'd5; req = 2'b01;
    step();
    check("t1_gnt", 32'(gnt_a), 32'h1);
    check("t1_en_first", 32'(en_a), 1);
    check("t1_up", 32'(up_a), 1);
    check("t1_busy", 32'(busy_a), 1);
    req = 2'b00;
    step();
    check("t1_gnt_pulse", 32'(gnt_a), 0);
    ens_a = 1;
    ens_b = 1;
    begin
      int c0;
      follow_burst(1'b1);
      c0 = cyc + 1;
      check("t1_en_cycles", 32'(ens_a + 1), 5);
      check("t1_done_latency", 32'(c0), 5);
    end
    check("t1_done", 32'(done_seen), 32'h1);
    check("t1_en_off", 32'(en_a), 0);
    check("t1_shadow", 32'(sh_a), 5);
    step();
    check("t1_done_pulse", 32'(done_a), 0);
    check("t1_idle", 32'(busy_a), 0);
    check("t1_up_hold", 32'(up_a), 1);

    // ---------------- simultaneous requests ----------------
    do_reset();
    dir = 2'b01; len0 = 4'd2; len1 = 4'd3; req = 2'b11;
    step();
    check("t2_gnt0", 32'(gnt_a), 32'h1);
    check("t2_owner0", 32'(owner_a), 0);
    req = 2'b10;
    follow_burst(1'b1);
    check("t2_en0", 32'(ens_a), 2);
    check("t2_done0", 32'(done_seen), 32'h1);
    check("t2_shadow0", 32'(sh_a), 2);
    step();
    check("t2_idle_nogrant", 32'(gnt_a), 0);
    step();
    check("t2_gnt1", 32'(gnt_a), 32'h2);
    check("t2_owner1", 32'(owner_a), 1);
    req = 2'b00;
    follow_burst(1'b0);
    check("t2_en1", 32'(ens_a), 3);
    check("t2_done1", 32'(done_seen), 32'h2);
    check("t2_shadow_wrap", 32'(sh_a), 32'hFF);
    check("t2_sat_en1", 32'(ens_b), 2);
    check("t2_sat_shadow", 32'(sh_b), 0);
    step();

    // ---------------- held requests alternate ----------------
    dir = 2'b11; len0 = 4'd1; len1 = 4'd1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      step();
      while (gnt_a == 2'b00 && w < 10) begin
        step();
        w++;
      end
      check("t3_alt_gnt", 32'(gnt_a), (k % 2 == 0) ? 32'h1 : 32'h2);
      follow_burst(1'b1);
      check("t3_alt_done", 32'(done_seen), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) req = 2'b00;
    end
    step();
    check("t3_shadow", 32'(sh_a), 32'h03);
    check("t3_sat_shadow", 32'(sh_b), 32'h04);

    // ---------------- zero length ----------------
    len1 = 4'd0; req = 2'b10;
    step();
    req = 2'b00;
    check("t4_gnt", 32'(gnt_a), 32'h2);
    check("t4_no_en", 32'(en_a), 0);
    check("t4_done", 32'(done_a), 32'h2);
    step();
    check("t4_done_pulse", 32'(done_a), 0);
    check("t4_idle", 32'(busy_a), 0);
    check("t4_shadow", 32'(sh_a), 32'h03);

    // ---------------- saturation near the top ----------------
    do_reset();
    for (int k = 0; k < 16; k++) run_cmd(0, 1'b1, 15);
    run_cmd(0, 1'b1, 14);
    check("t5_pre_a", 32'(sh_a), 32'hFE);
    check("t5_pre_b", 32'(sh_b), 32'hFE);
    run_cmd(0, 1'b1, 4);
    check("t5_len", 32'(cyc), 4);
    check("t5_done", 32'(done_seen), 32'h1);
    check("t5_sat_en", 32'(ens_b), 1);
    check("t5_sat_shadow", 32'(sh_b), 32'hFF);
    check("t5_wrap_en", 32'(ens_a), 4);
    check("t5_wrap_shadow", 32'(sh_a), 32'h02);

    // ---------------- reset mid-burst ----------------
    dir = 2'b01; len0 = 4'd8; req = 2'b01;
    step();
    req = 2'b00;
    step();
    step();
    check("t6_running", 32'(en_a), 1);
    rst = 1'b1;
    #1;
    check("t6_async_en", 32'(en_a), 0);
    check("t6_async_busy", 32'(busy_a), 0);
    check("t6_async_shadow", 32'(sh_a), 0);
    check("t6_async_done", 32'(done_a), 0);
    step();
    rst = 1'b0;
    step();
    check("t6_no_done", 32'(done_a), 0);
    run_cmd(1, 1'b0, 3);
    check("t6_fresh_done", 32'(done_seen), 32'h2);
    check("t6_fresh_en", 32'(ens_a), 3);
    check("t6_fresh_shadow", 32'(sh_a), 32'hFD);

    // ---------------- withdrawn and ignored requests ----------------
    dir = 2'b10; len1 = 4'd6; req = 2'b10;
    step();
    check("t7_gnt1", 32'(gnt_a), 32'h2);
    req = 2'b01; dir[0] = 1'b0; len0 = 4'd2;
    step();
    step();
    req = 2'b00; len0 = 4'd9;
    follow_burst(1'b1);
    check("t7_en", 32'(ens_a + 2), 6);
    check("t7_dir_kept", 32'(dir_bad), 0);
    check("t7_no_stray_gnt", 32'(stray_gnt), 0);
    check("t7_done", 32'(done_seen), 32'h2);
    check("t7_shadow", 32'(sh_a), 32'h03);
    begin
      int g;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        step();
        if (gnt_a != 2'b00) g++;
      end
      check("t7_withdrawn", 32'(g), 0);
    end

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
